// File: rtl/frame_word_reader_pkg.sv
// frame_word_reader_pkg
//   Items shared by the frame word reader, its raster counter and the
//   downstream window / result-writer path:
//     - default frame geometry (words per line, lines per frame)
//     - row / column tag widths
//     - FSM state encoding of the reader
//     - the row/column tag carried alongside each memory read
//     - a helper that decides whether a word completes a 3x2 window
package frame_word_reader_pkg;

    // Default geometry: 78 words per line (2 + 76 of the shift path) by 60 lines.
    localparam int WORDS_PER_LINE_DEF = 78;
    localparam int LINES_DEF          = 60;

    // Tag widths, shared with the window path.
    localparam int ROW_W = 8;
    localparam int COL_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fwr_state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } pix_tag_t;

    // A word completes a 3-row x 2-column window once two full rows are
    // already in the shift path and one earlier column exists in this row.
    function automatic logic window_ok(input logic [ROW_W-1:0] row,
                                       input logic [COL_W-1:0] col);
        return (row >= ROW_W'(2)) && (col >= COL_W'(1));
    endfunction

endpackage

// File: rtl/frame_word_reader_raster_counter.sv
// raster_counter
//   Column/row position counter in raster order.
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     i_clr        : return to (row 0, col 0)
//     i_en         : advance one position
//     o_col, o_row : current position
//     o_last       : current position is (ROWS-1, COLS-1)
//   The column wraps at COLS-1 and bumps the row; the row wraps at ROWS-1
//   so the counter can be reused frame after frame without a clear.
module raster_counter #(
    parameter int COLS  = 78,
    parameter int ROWS  = 60,
    parameter int COL_W = 7,
    parameter int ROW_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last
);

    localparam logic [COL_W-1:0] LP_COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LP_ROW_MAX = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (r_col == LP_COL_MAX) begin
                r_col <= '0;
                if (r_row == LP_ROW_MAX) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = (r_col == LP_COL_MAX) && (r_row == LP_ROW_MAX);

endmodule

// File: rtl/frame_word_reader.sv
// frame_word_reader
//   Reads one frame from a synchronous-read word memory in raster order and
//   pushes each word (one per write_en pulse) into the three-line window
//   shift path, tagged with its row/column and a window_valid flag.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     start, base_addr  : frame request; base_addr sampled when accepted
//     hold              : suspends issuing new reads (in-flight words finish)
//     mem_rd_en/addr    : registered read request to the frame store
//     mem_rd_data       : read data, valid the cycle after mem_rd_en
//     write_en,data_out : push strobe and word to the shift path
//     out_row, out_col  : position of the pushed word
//     window_valid      : push completes a 3-row x 2-column window
//     busy, done        : not-IDLE flag, end-of-frame pulse
//     dbg_state         : current FSM state, for observation only
//   Handshake: a read issued at edge n (mem_rd_en high after n) returns data
//   after n+1 and is pushed after n+2. Each stage carries a valid bit with its
//   row/col tag; nothing in flight is ever dropped except by rst.
module frame_word_reader
    import frame_word_reader_pkg::*;
#(
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int LINES          = LINES_DEF,   // 3 or more
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              write_en,
    output logic [DATA_W-1:0] data_out,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              window_valid,
    output logic              busy,
    output logic              done,
    output fwr_state_t        dbg_state
);

    fwr_state_t r_state;
    fwr_state_t w_state_nxt;

    logic              w_accept;    // start taken in IDLE
    logic              w_issue;     // a read goes out at this edge
    logic              w_drained;   // both pipe stages empty in DRAIN
    logic              w_busy;

    logic [COL_W-1:0]  w_rd_col;
    logic [ROW_W-1:0]  w_rd_row;
    logic              w_rd_last;

    logic [ADDR_W-1:0] r_addr;
    logic              r_mem_rd_en;
    logic [ADDR_W-1:0] r_mem_addr;
    pix_tag_t          r_tag1;       // tag of the read currently at the memory
    logic              r_v2;         // data for r_tag2 is on mem_rd_data
    pix_tag_t          r_tag2;
    logic              r_write_en;
    logic [DATA_W-1:0] r_data_out;
    logic [ROW_W-1:0]  r_out_row;
    logic [COL_W-1:0]  r_out_col;
    logic              r_window_valid;
    logic              r_done;

    // Read position counter; cleared when a frame is accepted.
    raster_counter #(
        .COLS  (WORDS_PER_LINE),
        .ROWS  (LINES),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_rd_pos (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_accept),
        .i_en   (w_issue),
        .o_col  (w_rd_col),
        .o_row  (w_rd_row),
        .o_last (w_rd_last)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!hold && w_rd_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Once both stages are empty the final push is on write_en
                // this cycle, so done lands on the cycle right after it.
                if (!r_mem_rd_en && !r_v2) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs / control strobes
    always_comb begin
        w_accept  = 1'b0;
        w_issue   = 1'b0;
        w_drained = 1'b0;
        w_busy    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy   = 1'b0;
                w_accept = start;
            end
            ST_FETCH: begin
                w_issue = !hold;
            end
            ST_DRAIN: begin
                w_drained = !r_mem_rd_en && !r_v2;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Address counter, read request and two-stage valid/tag pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr         <= '0;
            r_mem_rd_en    <= 1'b0;
            r_mem_addr     <= '0;
            r_tag1         <= '0;
            r_v2           <= 1'b0;
            r_tag2         <= '0;
            r_write_en     <= 1'b0;
            r_data_out     <= '0;
            r_out_row      <= '0;
            r_out_col      <= '0;
            r_window_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= base_addr;
            end else if (w_issue) begin
                r_addr <= r_addr + 1'b1;   // wraps modulo 2^ADDR_W
            end

            r_mem_rd_en <= w_issue;
            if (w_issue) begin
                r_mem_addr <= r_addr;
                r_tag1     <= '{row: w_rd_row, col: w_rd_col};
            end

            r_v2 <= r_mem_rd_en;
            if (r_mem_rd_en) begin
                r_tag2 <= r_tag1;
            end

            r_write_en     <= r_v2;
            r_window_valid <= r_v2 && window_ok(r_tag2.row, r_tag2.col);
            if (r_v2) begin
                r_data_out <= mem_rd_data;
                r_out_row  <= r_tag2.row;
                r_out_col  <= r_tag2.col;
            end

            r_done <= w_drained;
        end
    end

    assign mem_rd_en    = r_mem_rd_en;
    assign mem_addr     = r_mem_addr;
    assign write_en     = r_write_en;
    assign data_out     = r_data_out;
    assign out_row      = r_out_row;
    assign out_col      = r_out_col;
    assign window_valid = r_window_valid;
    assign busy         = w_busy;
    assign done         = r_done;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_frame_word_reader.sv
module tb_frame_word_reader;

  localparam int WPL = 78;
  localparam int LNS = 3;
  localparam int N   = WPL * LNS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        hold = 1'b0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic        write_en;
  logic [31:0] data_out;
  logic [7:0]  out_row;
  logic [6:0]  out_col;
  logic        window_valid;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  frame_word_reader #(
    .WORDS_PER_LINE (WPL),
    .LINES          (LNS),
    .ADDR_W         (16),
    .DATA_W         (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .hold         (hold),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .write_en     (write_en),
    .data_out     (data_out),
    .out_row      (out_row),
    .out_col      (out_col),
    .window_valid (window_valid),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame store model: memory[a] = a, one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= {16'h0000, mem_addr};
  end

  // ---------------- monitor: log pushes and done pulses ----------------
  logic [31:0] push_data[$];
  int          push_row[$];
  int          push_col[$];
  int          push_wv[$];
  int          push_cyc[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    if (write_en) begin
      push_data.push_back(data_out);
      push_row.push_back(int'(out_row));
      push_col.push_back(int'(out_col));
      push_wv.push_back(int'(window_valid));
      push_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    push_data.delete();
    push_row.delete();
    push_col.delete();
    push_wv.delete();
    push_cyc.delete();
    done_cyc.delete();
  endtask

  // ---------------- drivers ----------------
  // Issue start; c0 is the cycle number right after the accepting edge.
  task automatic kick(input logic [15:0] base, output int c0);
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    check_val("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Run a frame to done. hold rises when k = hold_at (delaying issue index
  // hold_at onwards) for hold_len cycles; a stray start is driven at k = stray_at.
  task automatic run_frame(input logic [15:0] base, input int hold_at, input int hold_len,
                           input int stray_at, output int c0);
    int  k;
    bit  seen;
    kick(base, c0);
    seen = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      k = cyc - c0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (k == 1 && hold_at != 0) begin
        check_val("first_rd_en", 32'(mem_rd_en), 32'd1);
        check_val("first_rd_addr", 32'(mem_addr), 32'(base));
      end
      hold  = (k >= hold_at) && (k < hold_at + hold_len);
      start = (k == stray_at);
      @(posedge clk); #1;
    end
    hold  = 1'b0;
    start = 1'b0;
    check_val("done_seen", 32'(seen), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Compare the logged frame against the raster model.
  task automatic verify_frame(input string name, input logic [15:0] base, input int c0,
                              input int hold_at, input int hold_len);
    int wv_cnt;
    int first_wv;
    int r;
    int c;
    int ecyc;
    logic [15:0] a;
    wv_cnt   = 0;
    first_wv = -1;
    check_val({name, "_push_count"}, 32'(push_data.size()), 32'(N));
    if (push_cyc.size() > 0)
      check_val({name, "_first_push_latency"}, 32'(push_cyc[0] - c0), 32'd3);
    for (int i = 0; i < push_data.size(); i++) begin
      a    = base + 16'(i);
      r    = i / WPL;
      c    = i % WPL;
      ecyc = c0 + 3 + i + ((i >= hold_at) ? hold_len : 0);
      check_val($sformatf("%s_data[%0d]", name, i), push_data[i], {16'h0000, a});
      check_val($sformatf("%s_row[%0d]", name, i), 32'(push_row[i]), 32'(r));
      check_val($sformatf("%s_col[%0d]", name, i), 32'(push_col[i]), 32'(c));
      check_val($sformatf("%s_wv[%0d]", name, i), 32'(push_wv[i]), 32'((r >= 2) && (c >= 1)));
      check_val($sformatf("%s_cyc[%0d]", name, i), 32'(push_cyc[i]), 32'(ecyc));
      if (push_wv[i] != 0) begin
        wv_cnt++;
        if (first_wv < 0) first_wv = i;
      end
    end
    check_val({name, "_wv_count"}, 32'(wv_cnt), 32'd77);
    if (first_wv >= 0)
      check_val({name, "_first_wv_data"}, push_data[first_wv], {16'h0000, base + 16'd157});
    check_val({name, "_done_count"}, 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0)
      check_val({name, "_done_cycle"}, 32'(done_cyc[0]), 32'(c0 + 3 + N + hold_len));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0;
    int k;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_write_en", 32'(write_en), 32'd0);
    check_val("rst_data_out", data_out, 32'd0);
    check_val("rst_out_row", 32'(out_row), 32'd0);
    check_val("rst_out_col", 32'(out_col), 32'd0);
    check_val("rst_window_valid", 32'(window_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);

    // Plain frame from 0x0100: last push is 0x1E9.
    run_frame(16'h0100, 1000, 0, -1, c0);
    verify_frame("plain", 16'h0100, c0, 1000, 0);
    if (push_data.size() > 0)
      check_val("plain_last_data", push_data[push_data.size()-1], 32'h0000_01E9);
    check_val("plain_idle_busy", 32'(busy), 32'd0);

    // Five-cycle hold at the 40th issue.
    run_frame(16'h0100, 39, 5, -1, c0);
    verify_frame("hold", 16'h0100, c0, 39, 5);

    // Stray start while busy is ignored.
    run_frame(16'h0100, 1000, 0, 100, c0);
    verify_frame("stray", 16'h0100, c0, 1000, 0);
    check_val("stray_stays_idle", 32'(busy), 32'd0);

    // Reset during push index 100.
    kick(16'h0100, c0);
    k = 0;
    while (cyc < c0 + 103 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("abort_reached", 32'(cyc), 32'(c0 + 103));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_write_en", 32'(write_en), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check_val("abort_push_count", 32'(push_data.size()), 32'd101);
    if (push_data.size() > 0)
      check_val("abort_last_data", push_data[push_data.size()-1], 32'h0000_0164);
    check_val("abort_no_done", 32'(done_cyc.size()), 32'd0);

    // Fresh frame after the abort refetches from base.
    run_frame(16'h0100, 1000, 0, -1, c0);
    verify_frame("refetch", 16'h0100, c0, 1000, 0);

    // Address wrap past 0xFFFF.
    run_frame(16'hFFF0, 1000, 0, -1, c0);
    verify_frame("wrap", 16'hFFF0, c0, 1000, 0);
    if (push_data.size() > 16)
      check_val("wrap_to_zero", push_data[16], 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_word_reader.md
# frame_word_reader

Fetches a source image from a synchronous-read word memory in raster order and pushes it, one 32-bit word per write pulse, into the three-line window shift path (`write_en` / `data_in` side). It also tags each pushed word with its row/column and flags words whose push completes a valid 3-row x 2-column window. It sits between the image frame store and the window/edge-detect pipeline, and is driven by a start/done handshake from the top-level controller.

## Interface
- `WORDS_PER_LINE`, 78, words per image line; equals the shift path line length (2 + 76).
- `LINES`, 60, lines per frame; legal range is 3 or more.
- `ADDR_W`, 16, memory address width.
- `DATA_W`, 32, word width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame request pulse; `base_addr` is sampled when it is accepted.
- `base_addr` in ADDR_W: address of word (row 0, col 0).
- `hold` in 1: while high, no new memory read is issued.
- `mem_rd_en` out 1: memory read strobe (registered).
- `mem_addr` out ADDR_W: memory read address (registered).
- `mem_rd_data` in DATA_W: read data, valid the cycle after `mem_rd_en`.
- `write_en` out 1: one-cycle push strobe to the shift path.
- `data_out` out DATA_W: pushed word, qualified by `write_en`.
- `out_row` out 8: row of the pushed word.
- `out_col` out 7: column of the pushed word.
- `window_valid` out 1: `write_en && out_row >= 2 && out_col >= 1`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last word has been pushed.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - `start` = 1 latches `base_addr` into the address counter, clears `rd_row`/`rd_col`, and moves to FETCH.
- FETCH, on each cycle with `hold` = 0:
  - Register `mem_rd_en` = 1 and `mem_addr` = current address.
  - Increment the address by 1, modulo 2^ADDR_W.
  - Advance `rd_col`; when `rd_col` is WORDS_PER_LINE-1 it wraps to 0 and `rd_row` increments.
  - Issuing (row LINES-1, col WORDS_PER_LINE-1) moves to DRAIN.
- FETCH, on each cycle with `hold` = 1: `mem_rd_en` = 0 and counters hold.
- Pipeline tag: row/col of each issued read travel with `mem_rd_en` through a 2-stage valid/tag pipe.
- Stage 2 registers `data_out <= mem_rd_data`, `write_en`, `out_row`, `out_col`, `window_valid`.
- DRAIN: waits until both pipe valids are 0 and the final `write_en` has been emitted, then pulses `done` and returns to IDLE.
- `done` is coincident with the first IDLE cycle.
- `hold` never cancels reads already issued; in-flight words are always pushed.
- `start` while `busy` = 1 is ignored. `start` in the same cycle `done` pulses (state IDLE) is accepted.
- Total pushes per frame are exactly WORDS_PER_LINE*LINES.

## Timing
- Reset values (all outputs 0, state IDLE):
  - `mem_rd_en`=0, `mem_addr`=0, `write_en`=0, `data_out`=0, `out_row`=0, `out_col`=0, `window_valid`=0, `busy`=0, `done`=0.
- `start` sampled at edge E0 gives:
  - `busy` = 1 after E0.
  - First `mem_rd_en` after E1.
  - Data returns after E2.
  - First `write_en` after E3.
- Start-to-first-push latency is 3 cycles.
- With `hold` = 0 throughout:
  - One push per cycle.
  - Last push after E(2 + N), where N = WORDS_PER_LINE*LINES.
  - `done` after E(3 + N).
- A `hold` of k cycles adds exactly k cycles.
- `rst` mid-frame:
  - Next cycle: state IDLE, pipe valids cleared, no further `write_en`, no `done`.
  - In-flight memory data is discarded.

## Structure
- The shared package holds:
  - Default geometry constants WORDS_PER_LINE_DEF = 78, LINES_DEF = 60.
  - The FSM state encoding.
  - Row/col widths, shared with the window path.
- One natural sub-module, `raster_counter`: col/row counter with wrap, enable, clear, and a last-position flag.
  - The counter is reused by the downstream result writer.

## Test plan
- Reset then `start` with `base_addr`=0x0100, WPL=78, LINES=3, memory[a]=a:
  - First `write_en` 3 cycles after start with `data_out`=0x100.
  - 234 consecutive pushes.
  - `done` one cycle after the push of 0x1E9.
- Same frame: `window_valid` first high at row 2, col 1 (`data_out`=0x19D).
  - `window_valid` is high on exactly 77 pushes.
- `hold` high for 5 cycles at the 40th issue:
  - Push stream contiguous in value with exactly a 5-cycle gap.
  - `done` delayed by 5 cycles.
  - No word lost or duplicated.
- `start` pulsed while busy:
  - Ignored.
  - Single `done` pulse.
  - Exactly 234 pushes.
- `rst` asserted at push 100:
  - `write_en`=0 from the following cycle.
  - `busy`=0, no `done`.
  - A new `start` refetches from `base_addr` with the first word correct.
- `base_addr`=0xFFF0:
  - Address wraps to 0x0000 after 0xFFFF.
  - Pushed data follows the wrapped addresses.
